channel_error_injector: RTL
===========================

// Module: channel_error_injector
// PURPOSE
//  Parametrised comms-channel error model between the Hamming encoder and decoder.
//  Streams W-bit codewords through a 1-deep valid/ready register stage.
//  Corrupts selected words using an internal LFSR.
//  Modes: pass-through, random N-bit flips, error bursts, or a fixed XOR mask.
//  Reports the applied error mask per word for the scoreboard, so decoder checks need no re-derivation.
// PARAMETERS
//  W          7             codeword width (>=2)
//  MAX_FLIPS  2             max bits flipped per corrupted word (1..W)
//  LFSR_SEED  32'hACE12468  LFSR reset value; 0 is illegal and is replaced by 1
//  BLEN_W     4             width of cfg_burst_len
// PORTS
//  clk            in   1         clock
//  rst            in   1         synchronous, active-high reset
//  cfg_mode       in   2         chan_pkg::fi_mode_t: OFF=0, RAND=1, BURST=2, FIXED=3
//  cfg_thresh     in   16        trigger when lfsr[15:0] < cfg_thresh; 16'hFFFF forces every word
//  cfg_nflip      in   clog2(MAX_FLIPS+1)  bits per error; 0 treated as 1, >MAX_FLIPS clamped
//  cfg_burst_len  in   BLEN_W    words per burst; 0 treated as 1
//  cfg_mask       in   W         XOR pattern used in FIXED mode
//  in_valid       in   1         input word valid
//  in_ready       out  1         = !out_valid || out_ready
//  in_data        in   W         codeword from encoder
//  out_valid      out  1         output word valid
//  out_ready      in   1         downstream accept
//  out_data       out  W         in_data ^ out_err_mask
//  out_err_mask   out  W         bits flipped in this word (0 if clean)
//  out_err        out  1         |out_err_mask
//  err_count      out  32        corrupted words since reset; saturates at 32'hFFFFFFFF
// BEHAVIOUR
//  - Reset: out_valid=0, out_data=0, out_err_mask=0, out_err=0, err_count=0, lfsr=LFSR_SEED, state=IDLE.
//  - Accept = in_valid && in_ready. Latency is 1 cycle (accept edge loads the output register).
//  - While out_valid && !out_ready, out_* hold stable.
//  - LFSR: 32-bit Galois, taps 32,22,2,1. Steps exactly once per accepted word, never otherwise.
//  - Config is sampled on the accept cycle only.
//  - trig = lfsr[15:0] < cfg_thresh, or cfg_thresh == 16'hFFFF.
//    cfg_thresh = 0 never triggers except BURST continuation.
//  - Rand mask: n = clamped cfg_nflip contiguous ones, rotated left by pos = lfsr[31:16] % W.
//    Wraps at bit W-1 -> bit 0. Bits are always distinct; popcount == n.
//  - OFF: mask=0 always. Any active burst is aborted (state->IDLE).
//  - RAND: mask = trig ? randmask : 0.
//  - FIXED: mask = trig ? cfg_mask : 0. cfg_mask=0 counts as clean (err_count unchanged).
//  - BURST FSM:
//    - IDLE: on accept with trig, the word gets a 1-bit randmask.
//      If len > 1, go to BURST with remaining = len-1.
//    - BURST: every accepted word gets a 1-bit randmask regardless of trig.
//      remaining decrements; at 1 -> IDLE.
//    - Mode leaving BURST mid-burst -> IDLE immediately, for that word too.
//  - err_count increments on accept when mask != 0.
//  - Reset mid-burst or mid-stall: outputs drop as in reset, the in-flight word is lost, and the LFSR restarts.
//    An identical stimulus then reproduces an identical error sequence.
//  - Simultaneous out_ready && in_valid with out_valid=1: the output is replaced in the same cycle (full throughput).
// CONFIGURATION
//  CEI_STATS_EN defined:
//    - Adds outputs bits_flipped[31:0] (sum of popcount(mask) per accepted word, saturating).
//    - Adds outputs words_seen[31:0] (accepted words, saturating). Both reset to 0.
//  Undefined: those ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  - chan_pkg: fi_mode_t enum, LFSR_TAPS constant, function rot_mask(n, pos, W).
//    Shared with the encoder/decoder bench.
//  - Sub-module lfsr32 (clk, rst, step, seed -> q): the Galois LFSR. Reused by the bench stimulus generator.
//  - Top holds the burst FSM, mask generation, output register and counters.
// TESTING
//  - OFF, thresh=FFFF, 20 words 0..19 -> out_data==in_data, out_err=0, err_count=0.
//  - RAND, thresh=FFFF, nflip=2, W=7, 50 words -> every mask has popcount 2, contiguous mod 7.
//    out_data^in_data==mask; err_count=50.
//  - FIXED, thresh=FFFF, cfg_mask=7'b0000101, in_data=7'h55 -> out_data=7'h50, out_err=1.
//  - BURST, len=3: thresh=FFFF for 1 word, then thresh=0 -> exactly 3 consecutive 1-bit errors, then clean words.
//    err_count=3. Repeat with len=0 -> 1 error.
//  - Backpressure: out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 and out_* stable.
//    The resulting error sequence equals a no-stall run (LFSR not stepped).
//  - rst asserted mid-burst (remaining=2) -> next cycle out_valid=0, err_count=0.
//    Rerun of the test-2 stimulus reproduces identical masks.

Source files
------------

// File: rtl/chan_pkg.sv
// rtl/chan_pkg.sv - shared channel error model types, LFSR taps and rotated-mask helper
package chan_pkg;

  typedef enum logic [1:0] {
    FI_OFF   = 2'd0,
    FI_RAND  = 2'd1,
    FI_BURST = 2'd2,
    FI_FIXED = 2'd3
  } fi_mode_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } burst_state_t;

  // Galois feedback for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  // n contiguous ones starting at bit pos, wrapping at bit w-1 -> 0 (w <= 32)
  function automatic logic [31:0] rot_mask(input int unsigned n, input int unsigned pos,
                                           input int unsigned w);
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < n) m = m | (32'd1 << ((pos + i) % w));
    end
    return m;
  endfunction

endpackage

// File: rtl/lfsr32.sv
// rtl/lfsr32.sv - 32-bit Galois LFSR, advances one step per cycle with step high
module lfsr32
  import chan_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  input  logic [31:0] seed,
  output logic [31:0] q
);

  logic [31:0] q_next;

  assign q_next = q[0] ? ((q >> 1) ^ LFSR_TAPS) : (q >> 1);

  // An all-zero state would lock up, so a zero seed is replaced by 1
  always_ff @(posedge clk) begin
    if (rst) q <= (seed == 32'd0) ? 32'd1 : seed;
    else if (step) q <= q_next;
  end

endmodule

// File: rtl/channel_error_injector.sv
// rtl/channel_error_injector.sv - channel error model (optional stats under CEI_STATS_EN)
module channel_error_injector
  import chan_pkg::*;
#(
  parameter int          W         = 7,
  parameter int          MAX_FLIPS = 2,
  parameter logic [31:0] LFSR_SEED = 32'hACE12468,
  parameter int          BLEN_W    = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [1:0]                         cfg_mode,
  input  logic [15:0]                        cfg_thresh,
  input  logic [$clog2(MAX_FLIPS+1)-1:0]     cfg_nflip,
  input  logic [BLEN_W-1:0]                  cfg_burst_len,
  input  logic [W-1:0]                       cfg_mask,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [W-1:0]                       in_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [W-1:0]                       out_data,
  output logic [W-1:0]                       out_err_mask,
  output logic                               out_err,
`ifdef CEI_STATS_EN
  output logic [31:0]                        bits_flipped,
  output logic [31:0]                        words_seen,
`endif
  output logic [31:0]                        err_count
);

  localparam int NF_W = $clog2(MAX_FLIPS + 1);

  fi_mode_t     mode;
  burst_state_t state, state_nxt;
  logic [BLEN_W-1:0] remaining, rem_nxt, blen_eff;
  logic [NF_W-1:0]   n_eff;
  logic [31:0]       lfsr_q;
  logic [15:0]       pos;
  logic              accept, trig;
  logic [W-1:0]      rand_mask, one_mask, mask_nxt;

  assign mode     = fi_mode_t'(cfg_mode);
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  lfsr32 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .step (accept),
    .seed (LFSR_SEED),
    .q    (lfsr_q)
  );

  assign trig = (lfsr_q[15:0] < cfg_thresh) || (cfg_thresh == 16'hFFFF);
  assign pos  = lfsr_q[31:16] % 16'(W);

  always_comb begin
    n_eff = cfg_nflip;
    if (cfg_nflip == '0) n_eff = NF_W'(1);
    else if (cfg_nflip > NF_W'(MAX_FLIPS)) n_eff = NF_W'(MAX_FLIPS);
  end

  assign blen_eff  = (cfg_burst_len == '0) ? BLEN_W'(1) : cfg_burst_len;
  assign rand_mask = W'(rot_mask(32'(n_eff), 32'(pos), W));
  assign one_mask  = W'(rot_mask(32'd1, 32'(pos), W));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      remaining <= '0;
    end else begin
      state     <= state_nxt;
      remaining <= rem_nxt;
    end
  end

  // Burst progress only moves on accepted words; leaving BURST mode aborts it
  always_comb begin
    state_nxt = state;
    rem_nxt   = remaining;
    if (accept) begin
      if (mode != FI_BURST) begin
        state_nxt = ST_IDLE;
      end else if (state == ST_BURST) begin
        if (remaining <= BLEN_W'(1)) state_nxt = ST_IDLE;
        else rem_nxt = remaining - BLEN_W'(1);
      end else if (trig && (blen_eff > BLEN_W'(1))) begin
        state_nxt = ST_BURST;
        rem_nxt   = blen_eff - BLEN_W'(1);
      end
    end
  end

  always_comb begin
    mask_nxt = '0;
    case (mode)
      FI_OFF:   mask_nxt = '0;
      FI_RAND:  mask_nxt = trig ? rand_mask : '0;
      FI_BURST: mask_nxt = (state == ST_BURST || trig) ? one_mask : '0;
      FI_FIXED: mask_nxt = trig ? cfg_mask : '0;
      default:  mask_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_err_mask <= '0;
      out_err      <= 1'b0;
      err_count    <= '0;
    end else begin
      if (accept) begin
        out_valid    <= 1'b1;
        out_data     <= in_data ^ mask_nxt;
        out_err_mask <= mask_nxt;
        out_err      <= |mask_nxt;
        if ((|mask_nxt) && (err_count != 32'hFFFF_FFFF)) err_count <= err_count + 32'd1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef CEI_STATS_EN
  logic [32:0] bits_sum;
  assign bits_sum = {1'b0, bits_flipped} + 33'($countones(mask_nxt));

  always_ff @(posedge clk) begin
    if (rst) begin
      bits_flipped <= '0;
      words_seen   <= '0;
    end else if (accept) begin
      bits_flipped <= bits_sum[32] ? 32'hFFFF_FFFF : bits_sum[31:0];
      if (words_seen != 32'hFFFF_FFFF) words_seen <= words_seen + 32'd1;
    end
  end
`endif

endmodule
